// File: rtl/sqrt_seq_ctrl.sv
// Sequencer for the iterative integer square root: one root bit per cycle, trial subtraction on a shared external adder.
// Latency: start accepted at T, done pulse at T+WIDTH/2+1; no backpressure, start is ignored while busy.
module sqrt_seq_ctrl #(
    parameter  int WIDTH = 32,
    localparam int AW    = WIDTH/2 + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     remainder,
    output logic [AW-1:0]        add_a,
    output logic [AW-1:0]        add_b,
    output logic                 add_cin,
    input  logic [AW-1:0]        add_sum,
    input  logic                 add_cout
);

    localparam int HW = WIDTH/2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   rad_sh;
    logic [HW:0]        rem;
    logic [HW-1:0]      rt;
    logic [CW-1:0]      count;

    logic [AW-1:0]      r4;
    logic [AW-1:0]      t;
    logic [HW:0]        rem_nxt;
    logic [HW-1:0]      rt_nxt;
    logic               unused_sum_hi;

    // rem is HW+1 bits and t is HW+2 bits, so both fit AW exactly / with one spare bit.
    assign r4 = {rem, rad_sh[WIDTH-1:WIDTH-2]};
    assign t  = {1'b0, rt, 2'b01};

    // add_cout=1 means r4 >= t: keep the difference and set the root bit.
    assign rem_nxt = add_cout ? add_sum[HW:0] : r4[HW:0];
    assign rt_nxt  = {rt[HW-2:0], add_cout};

    assign unused_sum_hi = ^add_sum[AW-1:HW+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ITER;
            S_ITER:  if (count == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_ITER: begin
                busy    = 1'b1;
                add_a   = r4;
                add_b   = ~t;
                add_cin = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_sh    <= '0;
            rem       <= '0;
            rt        <= '0;
            count     <= '0;
            root      <= '0;
            remainder <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rad_sh <= radicand;
                        rem    <= '0;
                        rt     <= '0;
                        count  <= CW'(HW - 1);
                    end
                end
                S_ITER: begin
                    rem    <= rem_nxt;
                    rt     <= rt_nxt;
                    rad_sh <= rad_sh << 2;
                    count  <= count - 1'b1;
                    // Results latch on the final iteration so they are valid alongside done.
                    if (count == '0) begin
                        root      <= rt_nxt;
                        remainder <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
